aes_core_requester: RTL and testbench
=====================================

Name: aes_core_requester

Overview:
- Initiator for the AES cipher-core endpoint protocol. It is the other end of the cipher-core wrapper's crypt, dec_key_gen and result endpoints, and the responder on that wrapper's entropy request endpoint.
- Accepts key configuration and a block stream from the control path, and issues decryption-key generation to the core when needed.
- Issues one crypt request per block, buffers each result, and presents it on an output stream. Sits between the AES register/control logic and the core wrapper.

Parameters:
- TimeoutCycles, 256: max cycles spent in any wait state before a timeout error.
- CntWidth, 32: width of the completed-block counter.
- LfsrSeed, 16'hACE1: reset value of the entropy LFSR (16-bit, taps 16,14,13,11).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- key_we_i  in  1  load key/key_len; accepted only when cfg_ready_o=1
- key_i  in  256  key words [7:0][31:0]
- key_len_i  in  3  AES_128=3'b001, AES_256=3'b100 (AES_192 illegal)
- cfg_ready_o  out  1  high in IDLE only
- blk_valid_i / blk_ready_o  in/out  1  input block handshake
- blk_data_i  in  128  input state
- blk_op_i  in  2  CIPH_FWD=2'b01, CIPH_INV=2'b10
- res_valid_o / res_ready_i  out/in  1  result handshake
- res_data_o  out  128  result state
- alert_fatal_i  in  1  forwarded to core ctrl[4]
- err_o  out  1  sticky: core alert, illegal key_len, or timeout
- blk_cnt_o  out  CntWidth  blocks completed, wraps
- core_crypt_valid_o / core_crypt_ack_i  out/in  1  crypt request
- core_crypt_o  out  128  block to core
- core_ctrl_o  out  6  {reseed=0, alert_fatal, force_masks=0, cfg_valid, op[1:0]}
- core_key_pack_o  out  256  registered key
- core_key_len_o  out  3  registered key_len
- core_dkg_req_valid_o / core_dkg_req_ack_i  out/in  1  dec-key-gen request
- core_dkg_req_o  out  1  constant 1
- core_crypt_res_valid_i / core_crypt_res_ack_o  in/out  1  crypt result
- core_crypt_res_i  in  258  [127:0] state, [129] alert
- core_dkg_res_valid_i / core_dkg_res_ack_o  in/out  1  dkg result
- core_dkg_res_i  in  1  alert
- core_entr_req_valid_i / core_entr_req_ack_o  in/out  1  entropy request
- core_entr_res_o  out  1  entropy bit

Behaviour:
- Reset values:
  - All valid and ack outputs are 0; err_o=0; blk_cnt_o=0; res_data_o=0.
  - Key registers are 0; key_loaded=0; dkg_done=0; LFSR=LfsrSeed.
  - State is IDLE.
- Reset mid-operation aborts immediately. Any core response still in flight after reset is ignored.
- cfg_valid (ctrl[2]) = key_loaded.
- FSM states: IDLE, DKG_REQ, DKG_WAIT, CRYPT_REQ, CRYPT_WAIT, OUT, ERROR.
- IDLE:
  - key_we_i: latch key and key_len, set key_loaded=1, clear dkg_done. An illegal key_len goes to ERROR.
  - Otherwise, blk_ready_o = key_loaded. On blk_valid_i&&blk_ready_o, latch data and op.
  - If op=INV && !dkg_done, go to DKG_REQ; else go to CRYPT_REQ.
  - key_we_i has priority over a simultaneous block: the block is not accepted that cycle.
- DKG_REQ: core_dkg_req_valid_o=1, held until core_dkg_req_ack_i. Then go to DKG_WAIT.
- DKG_WAIT: core_dkg_res_ack_o=1. On core_dkg_res_valid_i:
  - alert=1 goes to ERROR.
  - Otherwise set dkg_done=1 and go to CRYPT_REQ.
- CRYPT_REQ: core_crypt_valid_o=1 with the latched data and op, held stable until core_crypt_ack_i. Then go to CRYPT_WAIT.
- CRYPT_WAIT: core_crypt_res_ack_o=1. On core_crypt_res_valid_i:
  - Capture state[127:0] into res_data_o and increment blk_cnt_o.
  - alert set goes to ERROR; otherwise go to OUT.
- OUT: res_valid_o=1 and res_data_o held stable. On res_ready_i, go to IDLE.
- Latency: a block is accepted and core_crypt_valid_o rises the next cycle. A result captured in cycle N gives res_valid_o in cycle N+1.
- Timeout: a counter clears on entry to each of DKG_REQ, DKG_WAIT, CRYPT_REQ, CRYPT_WAIT. Reaching TimeoutCycles in that state goes to ERROR. OUT has no timeout.
- ERROR: err_o=1; all request valids and result acks are 0; blk_ready_o=0, cfg_ready_o=0. Left only by rst_i.
- Key reload while dkg_done=1 clears dkg_done, so the next INV block triggers a new dkg.
- Entropy responder is always active:
  - core_entr_req_ack_o = core_entr_req_valid_i, same cycle.
  - core_entr_res_o = LFSR[0].
  - LFSR advances only on a handshake.

Decomposition:
- aes_pkg additions:
  - req_state_e enum;
  - CIPH_FWD/CIPH_INV and key_len constants (existing aes_pkg values);
  - CTRL bit-index localparams;
  - RES_ALERT_BIT=129.
- Sub-module aes_entropy_lfsr: the LFSR plus valid/ack responder.

Test Plan:
- Encrypt: key 000102030405060708090a0b0c0d0e0f (AES_128), block 00112233445566778899aabbccddeeff, op FWD, against the real core wrapper. Required: res_data_o=69c4e0d86a7b0430d8cdb78070b4c55a, blk_cnt_o=1, no dkg request.
- Decrypt the same ciphertext, op INV. Required: exactly one dkg request, then res_data_o=00112233445566778899aabbccddeeff. A second INV block issues no dkg.
- Hold res_ready_i=0 for 20 cycles. Required: res_valid_o stays high, res_data_o stable, blk_ready_o=0. Release: IDLE next cycle.
- Stub core never asserts core_crypt_res_valid_i. Required: err_o=1 after TimeoutCycles in CRYPT_WAIT; all valids 0 until rst_i.
- Stub returns core_crypt_res_i[129]=1. Required: ERROR with err_o=1, blk_cnt_o=1, no res_valid_o.
- Assert rst_i during CRYPT_WAIT, then feed 3 entropy requests. Required: all outputs at reset values; entropy bits equal the first 3 LFSR bits from LfsrSeed.

Source files
------------

// File: rtl/aes_core_requester_pkg.sv
// Shared types and constants for the AES cipher-core requester slice.
// Encodings match the existing aes_pkg values used by the core wrapper.
package aes_core_requester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DKG_REQ,
    DKG_WAIT,
    CRYPT_REQ,
    CRYPT_WAIT,
    OUT,
    ERROR
  } req_state_e;

  localparam logic [1:0] CIPH_FWD = 2'b01;
  localparam logic [1:0] CIPH_INV = 2'b10;

  localparam logic [2:0] AES_128 = 3'b001;
  localparam logic [2:0] AES_256 = 3'b100;

  localparam int CTRL_WIDTH       = 6;
  localparam int CTRL_OP_LSB      = 0;
  localparam int CTRL_OP_MSB      = 1;
  localparam int CTRL_CFG_VALID   = 2;
  localparam int CTRL_FORCE_MASKS = 3;
  localparam int CTRL_ALERT_FATAL = 4;
  localparam int CTRL_RESEED      = 5;

  localparam int RES_WIDTH     = 258;
  localparam int RES_ALERT_BIT = 129;
  localparam int LFSR_WIDTH    = 16;

  // AES_192 is not supported by this requester, so it counts as illegal.
  function automatic logic key_len_legal(input logic [2:0] key_len);
    return (key_len == AES_128) || (key_len == AES_256);
  endfunction

endpackage

// File: rtl/aes_core_requester_if.sv
// Endpoint bundle between the requester (master) and the cipher-core wrapper (slave).
interface aes_core_requester_if;
  import aes_core_requester_pkg::*;

  logic                  crypt_valid;
  logic                  crypt_ack;
  logic [127:0]          crypt;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic [7:0][31:0]      key_pack;
  logic [2:0]            key_len;
  logic                  dkg_req_valid;
  logic                  dkg_req_ack;
  logic                  dkg_req;
  logic                  crypt_res_valid;
  logic                  crypt_res_ack;
  logic [RES_WIDTH-1:0]  crypt_res;
  logic                  dkg_res_valid;
  logic                  dkg_res_ack;
  logic                  dkg_res;
  logic                  entr_req_valid;
  logic                  entr_req_ack;
  logic                  entr_res;

  modport master (
    output crypt_valid, crypt, ctrl, key_pack, key_len, dkg_req_valid, dkg_req,
           crypt_res_ack, dkg_res_ack, entr_req_ack, entr_res,
    input  crypt_ack, dkg_req_ack, crypt_res_valid, crypt_res, dkg_res_valid,
           dkg_res, entr_req_valid
  );

  modport slave (
    input  crypt_valid, crypt, ctrl, key_pack, key_len, dkg_req_valid, dkg_req,
           crypt_res_ack, dkg_res_ack, entr_req_ack, entr_res,
    output crypt_ack, dkg_req_ack, crypt_res_valid, crypt_res, dkg_res_valid,
           dkg_res, entr_req_valid
  );

endinterface

// File: rtl/aes_core_requester_entropy_lfsr.sv
// Always-ready entropy responder: acks every request in the same cycle and
// serves LFSR bit 0, stepping the 16-bit Fibonacci LFSR only on a handshake.
module aes_core_requester_entropy_lfsr
  import aes_core_requester_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] Seed = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_valid,
  output logic req_ack,
  output logic entr_bit
);

  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  feedback;

  // Taps 16,14,13,11 expressed on a right-shifting register.
  assign feedback = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr <= Seed;
    end else if (req_valid) begin
      lfsr <= {feedback, lfsr[LFSR_WIDTH-1:1]};
    end
  end

  assign req_ack  = req_valid;
  assign entr_bit = lfsr[0];

endmodule

// File: rtl/aes_core_requester.sv
// Drives the cipher-core endpoints for one block at a time: optional decryption
// key generation, crypt request, result capture and hand-off on the output stream.
module aes_core_requester
  import aes_core_requester_pkg::*;
#(
  parameter int                    TimeoutCycles = 256,
  parameter int                    CntWidth      = 32,
  parameter logic [LFSR_WIDTH-1:0] LfsrSeed      = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                key_we_i,
  input  logic [7:0][31:0]    key_i,
  input  logic [2:0]          key_len_i,
  output logic                cfg_ready_o,
  input  logic                blk_valid_i,
  output logic                blk_ready_o,
  input  logic [127:0]        blk_data_i,
  input  logic [1:0]          blk_op_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [127:0]        res_data_o,
  input  logic                alert_fatal_i,
  output logic                err_o,
  output logic [CntWidth-1:0] blk_cnt_o,
  aes_core_requester_if.master core
);

  localparam int TmoWidth = $clog2(TimeoutCycles + 1);

  req_state_e            state;
  logic [7:0][31:0]      key_reg;
  logic [2:0]            key_len_reg;
  logic                  key_loaded;
  logic                  dkg_done;
  logic [127:0]          data_reg;
  logic [1:0]            op_reg;
  logic [127:0]          res_data;
  logic [CntWidth-1:0]   blk_cnt;
  logic [TmoWidth-1:0]   tmo_cnt;
  logic                  tmo_hit;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  unused_res_bits;

  assign tmo_hit = (tmo_cnt == TmoWidth'(TimeoutCycles - 1));

  // Every wait state restarts the timeout counter on entry; ERROR only exits via reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      key_reg     <= '0;
      key_len_reg <= '0;
      key_loaded  <= 1'b0;
      dkg_done    <= 1'b0;
      data_reg    <= '0;
      op_reg      <= '0;
      res_data    <= '0;
      blk_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_we_i) begin
            key_reg     <= key_i;
            key_len_reg <= key_len_i;
            key_loaded  <= 1'b1;
            dkg_done    <= 1'b0;
            if (!key_len_legal(key_len_i)) state <= ERROR;
          end else if (blk_valid_i && blk_ready_o) begin
            data_reg <= blk_data_i;
            op_reg   <= blk_op_i;
            tmo_cnt  <= '0;
            state    <= (blk_op_i == CIPH_INV && !dkg_done) ? DKG_REQ : CRYPT_REQ;
          end
        end
        DKG_REQ: begin
          if (core.dkg_req_ack) begin
            tmo_cnt <= '0;
            state   <= DKG_WAIT;
          end else if (tmo_hit) state <= ERROR;
          else tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
        DKG_WAIT: begin
          if (core.dkg_res_valid) begin
            tmo_cnt <= '0;
            if (core.dkg_res) begin
              state <= ERROR;
            end else begin
              dkg_done <= 1'b1;
              state    <= CRYPT_REQ;
            end
          end else if (tmo_hit) state <= ERROR;
          else tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
        CRYPT_REQ: begin
          if (core.crypt_ack) begin
            tmo_cnt <= '0;
            state   <= CRYPT_WAIT;
          end else if (tmo_hit) state <= ERROR;
          else tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
        CRYPT_WAIT: begin
          // An alerted result still counts as a completed block.
          if (core.crypt_res_valid) begin
            res_data <= core.crypt_res[127:0];
            blk_cnt  <= blk_cnt + CntWidth'(1);
            state    <= core.crypt_res[RES_ALERT_BIT] ? ERROR : OUT;
          end else if (tmo_hit) state <= ERROR;
          else tmo_cnt <= tmo_cnt + TmoWidth'(1);
        end
        OUT: begin
          if (res_ready_i) state <= IDLE;
        end
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

  always_comb begin
    ctrl                              = '0;
    ctrl[CTRL_OP_MSB:CTRL_OP_LSB]     = op_reg;
    ctrl[CTRL_CFG_VALID]              = key_loaded;
    ctrl[CTRL_FORCE_MASKS]            = 1'b0;
    ctrl[CTRL_ALERT_FATAL]            = alert_fatal_i;
    ctrl[CTRL_RESEED]                 = 1'b0;
  end

  // A key write in the same cycle wins, so the block must not see ready.
  assign cfg_ready_o = (state == IDLE);
  assign blk_ready_o = (state == IDLE) && key_loaded && !key_we_i;
  assign res_valid_o = (state == OUT);
  assign res_data_o  = res_data;
  assign err_o       = (state == ERROR);
  assign blk_cnt_o   = blk_cnt;

  assign core.crypt_valid   = (state == CRYPT_REQ);
  assign core.crypt         = data_reg;
  assign core.ctrl          = ctrl;
  assign core.key_pack      = key_reg;
  assign core.key_len       = key_len_reg;
  assign core.dkg_req_valid = (state == DKG_REQ);
  assign core.dkg_req       = 1'b1;
  assign core.crypt_res_ack = (state == CRYPT_WAIT);
  assign core.dkg_res_ack   = (state == DKG_WAIT);

  assign unused_res_bits = ^{core.crypt_res[RES_WIDTH-1:RES_ALERT_BIT+1], core.crypt_res[128]};

  aes_core_requester_entropy_lfsr #(
    .Seed(LfsrSeed)
  ) u_entropy (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_valid(core.entr_req_valid),
    .req_ack  (core.entr_req_ack),
    .entr_bit (core.entr_res)
  );

endmodule

// File: tb/tb_aes_core_requester.sv
// Scoreboard bench for aes_core_requester with a behavioural cipher-core stub
// that knows the FIPS-197 AES-128 vector and inverts any other block.
module tb_aes_core_requester;
  import aes_core_requester_pkg::*;

  localparam int TCyc = 256;
  localparam int STUB_NORMAL = 0;
  localparam int STUB_HANG   = 1;
  localparam int STUB_ALERT  = 2;
  localparam logic [255:0] KEY = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef logic [257:0] vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             key_we;
  logic [7:0][31:0] key;
  logic [2:0]       key_len;
  logic             cfg_ready;
  logic             blk_valid;
  logic             blk_ready;
  logic [127:0]     blk_data;
  logic [1:0]       blk_op;
  logic             res_valid;
  logic             res_ready;
  logic [127:0]     res_data;
  logic             alert_fatal;
  logic             err;
  logic [31:0]      blk_cnt;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic [127:0] exp_q[$];
  bit res_seen;

  int stub_mode = STUB_NORMAL;
  int dkg_req_cnt = 0;
  bit c_busy, d_busy;
  int c_dly, d_dly;
  logic [127:0] c_data;
  logic [1:0] c_op;

  aes_core_requester_if cif();

  aes_core_requester #(
    .TimeoutCycles(TCyc),
    .CntWidth     (32),
    .LfsrSeed     (16'hACE1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .key_we_i     (key_we),
    .key_i        (key),
    .key_len_i    (key_len),
    .cfg_ready_o  (cfg_ready),
    .blk_valid_i  (blk_valid),
    .blk_ready_o  (blk_ready),
    .blk_data_i   (blk_data),
    .blk_op_i     (blk_op),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data),
    .alert_fatal_i(alert_fatal),
    .err_o        (err),
    .blk_cnt_o    (blk_cnt),
    .core         (cif)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input vec_t actual, input vec_t expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic vec_t coreModel(input logic [127:0] d, input logic [1:0] op, input bit alert);
    vec_t r;
    r = '0;
    if (op == CIPH_FWD && d == PT && cif.key_pack == KEY) r[127:0] = CT;
    else if (op == CIPH_INV && d == CT && cif.key_pack == KEY) r[127:0] = PT;
    else r[127:0] = ~d;
    r[128] = 1'b1;
    r[257:130] = {128{1'b1}};
    r[RES_ALERT_BIT] = alert;
    return r;
  endfunction

  // Core stub: acks requests at the falling edge, answers after a short delay.
  initial begin
    cif.crypt_ack = 0; cif.dkg_req_ack = 0; cif.crypt_res_valid = 0; cif.crypt_res = '0;
    cif.dkg_res_valid = 0; cif.dkg_res = 0; cif.entr_req_valid = 0;
    c_busy = 0; d_busy = 0;
    forever begin
      @(negedge clk);
      cif.crypt_ack = 0; cif.dkg_req_ack = 0; cif.crypt_res_valid = 0; cif.dkg_res_valid = 0;
      if (rst) begin
        c_busy = 0; d_busy = 0;
      end else begin
        if (cif.dkg_req_valid && !d_busy) begin
          cif.dkg_req_ack = 1; d_busy = 1; d_dly = 3; dkg_req_cnt++;
        end else if (d_busy) begin
          if (d_dly > 0) d_dly--;
          else begin cif.dkg_res_valid = 1; cif.dkg_res = 0; d_busy = 0; end
        end
        if (cif.crypt_valid && !c_busy) begin
          cif.crypt_ack = 1; c_busy = 1; c_dly = 4; c_data = cif.crypt; c_op = cif.ctrl[1:0];
        end else if (c_busy && stub_mode != STUB_HANG) begin
          if (c_dly > 0) c_dly--;
          else begin
            cif.crypt_res_valid = 1;
            cif.crypt_res = coreModel(c_data, c_op, stub_mode == STUB_ALERT);
            c_busy = 0;
          end
        end
      end
    end
  end

  // Result monitor pops the scoreboard on each output handshake.
  initial begin
    logic [127:0] exp_v;
    forever begin
      @(negedge clk); #1;
      if (!rst && res_valid) res_seen = 1;
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) checkOutput("unexp_res", vec_t'(res_valid), vec_t'(0));
        else begin
          exp_v = exp_q.pop_front();
          checkOutput("res_data", vec_t'(res_data), vec_t'(exp_v));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d vectors applied", n_vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic resetDut();
    @(negedge clk); rst = 1; blk_valid = 0; key_we = 0; res_ready = 1;
    repeat (2) @(negedge clk);
    rst = 0; #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_hs"}, vec_t'({err, res_valid, cfg_ready, blk_ready, cif.crypt_valid,
                cif.dkg_req_valid, cif.crypt_res_ack, cif.dkg_res_ack}), vec_t'(8'b0010_0000));
    checkOutput({tag, "_cnt"}, vec_t'(blk_cnt), vec_t'(0));
    checkOutput({tag, "_res"}, vec_t'(res_data), vec_t'(0));
    checkOutput({tag, "_key"}, vec_t'({cif.key_pack, cif.key_len, cif.ctrl[CTRL_CFG_VALID]}), vec_t'(0));
    checkOutput({tag, "_entr"}, vec_t'(cif.entr_res), vec_t'(1));
  endtask

  task automatic loadKey(input logic [255:0] k, input logic [2:0] kl);
    @(negedge clk); key_we = 1; key = k; key_len = kl;
    @(negedge clk); key_we = 0; #1;
  endtask

  task automatic applyStimulus(input logic [127:0] d, input logic [1:0] op,
                               input logic [127:0] exp_v, input bit push, input bit expect_dkg);
    int guard;
    @(negedge clk); blk_valid = 1; blk_data = d; blk_op = op; #1;
    guard = 0;
    while (!blk_ready && guard < 200) begin @(negedge clk); #1; guard++; end
    checkOutput("blk_accept", vec_t'(blk_ready), vec_t'(1));
    if (push) exp_q.push_back(exp_v);
    @(negedge clk); blk_valid = 0; #1;
    if (expect_dkg) checkOutput("dkg_rise", vec_t'({cif.dkg_req_valid, cif.crypt_valid}), vec_t'(2'b10));
    else checkOutput("crypt_rise", vec_t'({cif.crypt_valid, cif.crypt, cif.ctrl[1:0]}), vec_t'({1'b1, d, op}));
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((exp_q.size() != 0 || !cfg_ready) && guard < 300) begin @(negedge clk); #1; guard++; end
    checkOutput("drain", vec_t'(cfg_ready), vec_t'(1));
  endtask

  task automatic waitErr(input int bound);
    int guard = 0;
    while (!err && guard < bound) begin @(negedge clk); #1; guard++; end
  endtask

  initial begin
    logic [127:0] d;
    logic [2:0] exp_bits;
    int n;
    rst = 1; key_we = 0; key = '0; key_len = '0; blk_valid = 0; blk_data = '0;
    blk_op = '0; res_ready = 1; alert_fatal = 0; exp_bits = 3'b001;
    repeat (3) @(negedge clk);
    #1;
    checkResetState("rst");
    rst = 0;

    loadKey(KEY, AES_128);
    checkOutput("key_regs", vec_t'({cif.key_pack, cif.key_len, cif.ctrl[CTRL_CFG_VALID], cif.dkg_req}),
                vec_t'({KEY, AES_128, 1'b1, 1'b1}));
    @(negedge clk); alert_fatal = 1; #1;
    checkOutput("alert_fwd", vec_t'(cif.ctrl[5:3]), vec_t'(3'b010));
    @(negedge clk); alert_fatal = 0;

    applyStimulus(PT, CIPH_FWD, CT, 1, 0);
    waitDrain();
    checkOutput("enc_cnt", vec_t'({blk_cnt, 8'(dkg_req_cnt)}), vec_t'({32'd1, 8'd0}));

    applyStimulus(CT, CIPH_INV, PT, 1, 1);
    applyStimulus(CT, CIPH_INV, PT, 1, 0);
    waitDrain();
    checkOutput("dec_dkg", vec_t'({blk_cnt, 8'(dkg_req_cnt)}), vec_t'({32'd3, 8'd1}));

    for (int i = 0; i < 4; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(d, CIPH_FWD, ~d, 1, 0);
    end
    waitDrain();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cif.entr_req_valid = 1; #1;
      checkOutput("entr_ack", vec_t'(cif.entr_req_ack), vec_t'(1));
    end
    @(negedge clk); cif.entr_req_valid = 0;

    res_ready = 0;
    applyStimulus(PT, CIPH_FWD, CT, 1, 0);
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      checkOutput("hold", vec_t'({res_valid, blk_ready, res_data}), vec_t'({1'b1, 1'b0, CT}));
    end
    @(negedge clk); res_ready = 1;
    @(negedge clk); #1;
    checkOutput("release", vec_t'({res_valid, cfg_ready}), vec_t'(2'b01));

    loadKey(KEY, AES_128);
    applyStimulus(CT, CIPH_INV, PT, 1, 1);
    waitDrain();
    checkOutput("reload_dkg", vec_t'({blk_cnt, 8'(dkg_req_cnt)}), vec_t'({32'd9, 8'd2}));

    resetDut();
    loadKey(KEY, 3'b010);
    checkOutput("bad_keylen", vec_t'({err, cfg_ready}), vec_t'(2'b10));

    resetDut();
    stub_mode = STUB_HANG;
    loadKey(KEY, AES_128);
    applyStimulus(PT, CIPH_FWD, '0, 0, 0);
    n = 0;
    while (!cif.crypt_res_ack && n < 50) begin @(negedge clk); #1; n++; end
    n = 0;
    while (!err && n < 2 * TCyc) begin
      if (cif.crypt_res_ack) n++;
      @(negedge clk); #1;
    end
    checkOutput("tmo_cycles", vec_t'(n), vec_t'(TCyc));
    checkOutput("tmo_err", vec_t'(err), vec_t'(1));
    blk_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checkOutput("err_quiet", vec_t'({err, cif.crypt_valid, cif.dkg_req_valid, cif.crypt_res_ack,
                  cif.dkg_res_ack, res_valid, blk_ready, cfg_ready}), vec_t'(8'b1000_0000));
    end
    blk_valid = 0;

    resetDut();
    stub_mode = STUB_ALERT;
    res_seen = 0;
    loadKey(KEY, AES_128);
    applyStimulus(PT, CIPH_FWD, '0, 0, 0);
    waitErr(50);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("alert_err", vec_t'({err, blk_cnt, res_seen}), vec_t'({1'b1, 32'd1, 1'b0}));

    resetDut();
    stub_mode = STUB_HANG;
    loadKey(KEY, AES_128);
    applyStimulus(PT, CIPH_FWD, '0, 0, 0);
    n = 0;
    while (!cif.crypt_res_ack && n < 50) begin @(negedge clk); #1; n++; end
    checkOutput("in_crypt_wait", vec_t'(cif.crypt_res_ack), vec_t'(1));
    stub_mode = STUB_NORMAL;
    resetDut();
    checkResetState("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cif.entr_req_valid = 1; #1;
      checkOutput($sformatf("entr_bit%0d", i), vec_t'({cif.entr_req_ack, cif.entr_res}),
                  vec_t'({1'b1, exp_bits[i]}));
    end
    @(negedge clk); cif.entr_req_valid = 0; #1;
    checkOutput("entr_idle", vec_t'(cif.entr_req_ack), vec_t'(0));
    repeat (10) @(negedge clk);
    #1;
    checkOutput("quiet_after_rst", vec_t'({res_valid, err, blk_cnt}), vec_t'(0));
    checkOutput("sb_left", vec_t'(exp_q.size()), vec_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
